// File: rtl/block_check_arbiter.sv
// Round-robin arbiter that time-shares one begin/end nesting checker between two
// character-stream requesters and reports a tagged balanced/unbalanced result per text.
module block_check_arbiter #(
    parameter int DEPTH_W = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       res_valid,
    output logic       res_id,
    output logic       res_ok,
    input  logic       res_ready,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
    typedef enum logic [3:0] {WS, B1, B2, B3, B4, B5, E1, E2, E3, WX} word_t;

    state_t               state, state_n;
    word_t                ws, ws_a, ws_n;
    logic                 grant, last_served;
    logic [DEPTH_W-1:0]   depth, depth_a, depth_b, depth_n;
    logic                 err, err_a, err_b, err_n;
    logic                 beat_valid, beat_last, accept;
    logic [7:0]           beat_data;

    // Letters only alias under OR 0x20 with their own upper case, so this folds case safely.
    function automatic word_t step(input word_t w, input logic [7:0] c);
        logic [7:0] lc;
        lc = c | 8'h20;
        case (w)
            WS:      step = (lc == "b") ? B1 : (lc == "e") ? E1 : WX;
            B1:      step = (lc == "e") ? B2 : WX;
            B2:      step = (lc == "g") ? B3 : WX;
            B3:      step = (lc == "i") ? B4 : WX;
            B4:      step = (lc == "n") ? B5 : WX;
            E1:      step = (lc == "n") ? E2 : WX;
            E2:      step = (lc == "d") ? E3 : WX;
            default: step = WX;
        endcase
    endfunction

    // Returns {err, depth} after a word boundary; saturates instead of wrapping.
    function automatic logic [DEPTH_W:0] commit(input word_t w, input logic [DEPTH_W-1:0] d,
                                                input logic e);
        logic [DEPTH_W-1:0] dn;
        logic               en;
        dn = d;
        en = e;
        if (w == B5) begin
            if (&d) en = 1'b1;
            else    dn = d + 1'b1;
        end else if (w == E3) begin
            if (d == '0) en = 1'b1;
            else         dn = d - 1'b1;
        end
        commit = {en, dn};
    endfunction

    assign beat_valid = grant ? req1_valid : req0_valid;
    assign beat_data  = grant ? req1_data  : req0_data;
    assign beat_last  = grant ? req1_last  : req0_last;
    assign accept     = (state == RUN) && beat_valid;

    // The last beat gets an implicit trailing space applied right after its own character.
    always_comb begin
        ws_a    = ws;
        depth_a = depth;
        err_a   = err;
        if (beat_data == 8'h20) begin
            {err_a, depth_a} = commit(ws, depth, err);
            ws_a = WS;
        end else begin
            ws_a = step(ws, beat_data);
        end
        {err_b, depth_b} = commit(ws_a, depth_a, err_a);
        ws_n    = beat_last ? WS      : ws_a;
        depth_n = beat_last ? depth_b : depth_a;
        err_n   = beat_last ? err_b   : err_a;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_n = RUN;
            RUN:     if (accept && beat_last)      state_n = REPORT;
            REPORT:  if (res_ready)                state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == RUN) && !grant;
        req1_ready = (state == RUN) &&  grant;
        res_valid  = (state == REPORT);
        res_id     = (state == REPORT) && grant;
        res_ok     = (state == REPORT) && !err && (depth == '0);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            if (state == IDLE && (req0_valid || req1_valid))
                grant <= (req0_valid && req1_valid) ? !last_served : req1_valid;
            if (accept && beat_last)
                last_served <= grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ws    <= WS;
            depth <= '0;
            err   <= 1'b0;
        end else if (state == REPORT && res_ready) begin
            ws    <= WS;
            depth <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            ws    <= ws_n;
            depth <= depth_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_block_check_arbiter.sv
// Directed bench for block_check_arbiter using a 2-bit depth counter so overflow is reachable.
module tb_block_check_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [7:0] req1_data = 8'h00;
    logic       res_valid, res_id, res_ok, busy;
    logic       res_ready = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int first_wait;
    bit other_seen;

    block_check_arbiter #(.DEPTH_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_id(res_id), .res_ok(res_ok), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input logic v, input logic [7:0] d, input logic l);
        if (id) begin req1_valid = v; req1_data = d; req1_last = l; end
        else    begin req0_valid = v; req0_data = d; req0_last = l; end
    endtask

    function automatic logic rdy(input bit id);
        return id ? req1_ready : req0_ready;
    endfunction

    // Sends one text; stall_at >= 0 drops valid for 3 cycles before that character.
    task automatic send(input bit id, input string s, input bit do_last, input int stall_at);
        int n;
        other_seen = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if (i == stall_at) begin
                drive(id, 1'b0, 8'h00, 1'b0);
                repeat (3) begin @(posedge clk); #1; end
            end
            drive(id, 1'b1, s[i], do_last && (i == s.len() - 1));
            n = 0;
            while (!rdy(id) && n < 20) begin
                if (rdy(!id)) other_seen = 1'b1;
                @(posedge clk); #1;
                n++;
            end
            if (i == 0) first_wait = n;
            if (n >= 20) begin
                n_assert++;
                n_fail++;
                $display("FAIL beat_timeout: req%0d ready observed 0 for %0d cycles, required 1", id, n);
                drive(id, 1'b0, 8'h00, 1'b0);
                return;
            end
            if (rdy(!id)) other_seen = 1'b1;
            @(posedge clk); #1;
        end
        drive(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic result(input string tag, input bit id, input bit ok);
        chk({tag, "_res_valid"}, res_valid, 1);
        chk({tag, "_res_id"}, res_id, id);
        chk({tag, "_res_ok"}, res_ok, ok);
        chk({tag, "_readys"}, {req0_ready, req1_ready}, 0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_res_drop"}, res_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_outs", {req0_ready, req1_ready, res_valid, res_id, res_ok, busy}, 0);

        // Single requester, grant latency of one cycle.
        send(0, "begin end", 1, -1);
        chk("t1_latency", first_wait, 1);
        result("t1", 0, 1);

        // Tie from reset goes to req0; req1 then served with sticky underflow.
        do_reset();
        drive(1, 1'b1, "e", 1'b0);
        send(0, "BEGIN x End", 1, -1);
        chk("t2_latency0", first_wait, 1);
        chk("t2_req1_blocked", other_seen, 0);
        result("t2a", 0, 1);
        send(1, "end begin", 1, -1);
        chk("t2_latency1", first_wait, 1);
        result("t2b", 1, 0);

        // Partial keywords and tokenizer clearing between texts.
        send(0, "begins beginn begin", 1, -1);
        result("t3a", 0, 0);
        send(0, "begin end", 1, -1);
        result("t3b", 0, 1);
        send(0, "begin end end begin", 1, -1);
        result("t3c", 0, 0);
        send(0, "begin end", 1, -1);
        result("t3d", 0, 1);

        // Result held under backpressure; req0 waiting is not served meanwhile.
        drive(0, 1'b1, "x", 1'b1);
        send(1, "begin  end", 1, -1);
        chk("t4_req0_blocked", other_seen, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold", {res_valid, res_id, res_ok, req0_ready, req1_ready}, 5'b11100);
            @(posedge clk); #1;
        end
        result("t4a", 1, 1);
        send(0, "x", 1, -1);
        chk("t4_latency", first_wait, 1);
        result("t4b", 0, 1);

        // Asynchronous reset mid-text drops the text with no result.
        send(0, "begin ", 0, -1);
        chk("t5_running", {busy, req0_ready}, 2'b11);
        #2 reset_n = 1'b0;
        #1 chk("t5_async", {req0_ready, req1_ready, res_valid, res_id, res_ok, busy}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        chk("t5_no_result", res_valid, 0);
        send(0, "end", 1, -1);
        chk("t5_latency", first_wait, 1);
        result("t5", 0, 0);

        // Depth saturation with a 2-bit counter, and a mid-word valid stall.
        send(0, "begin begin begin end end end", 1, -1);
        result("t6a", 0, 1);
        send(0, "begin begin begin begin end end end", 1, -1);
        result("t6b", 0, 0);
        send(1, "begin end", 1, 2);
        result("t6c", 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded bound");
        $fatal(1, "timeout");
    end

endmodule
